// File: rtl/data_bus_lat_shim.sv
// data_bus_lat_shim
// Adds latency between the core data port and a single-cycle data memory.
// Grants are held off by a pseudo-random number of wait states, and each
// response is held back by a pseudo-random extra delay. Responses are
// queued and returned in grant order. A requester that withdraws or changes
// a pending request sets a sticky protocol-error flag.
//
// Ports
//   clk_i, rst_ni             clock, async active-low reset
//   gnt_wmax_i, resp_wmax_i   upper bounds for the grant wait / response delay draws
//   data_*                    OBI-style requester side (core)
//   mem_*                     single-cycle memory side (rdata/err valid the cycle after cs)
//   proto_err_o               sticky requester protocol violation
//
// Grant FSM
//   state | meaning
//   IDLE  | no request pending; zero-wait grants are issued directly from here
//   WAIT  | request pending; counting down wait states or stalled on occupancy
module data_bus_lat_shim #(
  parameter int unsigned Depth     = 4,
  parameter int unsigned DataWidth = 33,
  parameter logic [15:0] Seed      = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [3:0]           gnt_wmax_i,
  input  logic [3:0]           resp_wmax_i,
  input  logic                 data_req_i,
  input  logic                 data_we_i,
  input  logic [3:0]           data_be_i,
  input  logic                 data_is_cap_i,
  input  logic [31:0]          data_addr_i,
  input  logic [DataWidth-1:0] data_wdata_i,
  output logic                 data_gnt_o,
  output logic                 data_rvalid_o,
  output logic                 data_err_o,
  output logic [DataWidth-1:0] data_rdata_o,
  output logic                 mem_cs_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_be_o,
  output logic                 mem_is_cap_o,
  output logic [31:0]          mem_addr_o,
  output logic [DataWidth-1:0] mem_wdata_o,
  input  logic [DataWidth-1:0] mem_rdata_i,
  input  logic                 mem_err_i,
  output logic                 proto_err_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned OccW = CntW + 1;
  localparam logic [15:0] SeedEff  = (Seed == 16'h0000) ? 16'h0001 : Seed;
  localparam logic [15:0] LfsrPoly = 16'hB400;

  typedef enum logic {IDLE, WAIT} state_e;

  typedef struct packed {
    logic [DataWidth-1:0] rdata;
    logic                 err;
    logic [3:0]           dly;
  } entry_t;

  logic [15:0]          lfsr_q, lfsr_d;
  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 inflight_q, inflight_d;
  logic                 proto_err_q, proto_err_d;
  logic [31:0]          hold_addr_q, hold_addr_d;
  logic                 hold_we_q, hold_we_d;
  logic [3:0]           hold_be_q, hold_be_d;
  logic [DataWidth-1:0] hold_wdata_q, hold_wdata_d;
  entry_t               fifo_q [Depth];
  entry_t               fifo_d [Depth];
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 rvalid_q, rvalid_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] rdata_q, rdata_d;

  logic [3:0]      w_draw, d_draw;
  logic [OccW-1:0] occ;
  logic            space, gnt, req_changed;
  logic            push, pop, store;
  entry_t          head, store_entry;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrPoly : 16'h0000);
  assign w_draw = 4'({1'b0, lfsr_q[3:0]} % ({1'b0, gnt_wmax_i} + 5'd1));
  assign d_draw = 4'({1'b0, lfsr_q[7:4]} % ({1'b0, resp_wmax_i} + 5'd1));

  assign occ   = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
  assign space = (occ < OccW'(Depth));

  assign req_changed = (data_addr_i != hold_addr_q) || (data_we_i != hold_we_q) ||
                       (data_be_i != hold_be_q) || (data_wdata_i != hold_wdata_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gnt          = 1'b0;
    proto_err_d  = proto_err_q;
    hold_addr_d  = hold_addr_q;
    hold_we_d    = hold_we_q;
    hold_be_d    = hold_be_q;
    hold_wdata_d = hold_wdata_q;
    case (state_q)
      IDLE: begin
        if (data_req_i) begin
          if (w_draw == 4'd0 && space) begin
            gnt = 1'b1;
          end else begin
            state_d      = WAIT;
            cnt_d        = w_draw;
            hold_addr_d  = data_addr_i;
            hold_we_d    = data_we_i;
            hold_be_d    = data_be_i;
            hold_wdata_d = data_wdata_i;
          end
        end
      end
      WAIT: begin
        if (!data_req_i) begin
          proto_err_d = 1'b1;
          state_d     = IDLE;
        end else begin
          if (req_changed) proto_err_d = 1'b1;
          if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (space) begin
            gnt     = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held, even with a request present.
  assign data_gnt_o   = gnt & rst_ni;
  assign inflight_d   = data_gnt_o;
  assign mem_cs_o     = data_gnt_o;
  assign mem_we_o     = data_gnt_o & data_we_i;
  assign mem_be_o     = data_gnt_o ? data_be_i : 4'h0;
  assign mem_is_cap_o = data_gnt_o & data_is_cap_i;
  assign mem_addr_o   = data_gnt_o ? data_addr_i : 32'h0;
  assign mem_wdata_o  = data_gnt_o ? data_wdata_i : '0;

  // Response queue. An access arriving at an empty queue is already the head
  // in its capture cycle, so that cycle counts as one unit of its delay; a
  // zero delay bypasses storage entirely to give the two-cycle response.
  always_comb begin
    push        = inflight_q;
    head        = fifo_q[rd_ptr_q];
    store_entry = '{rdata: mem_rdata_i, err: mem_err_i, dly: d_draw};
    pop         = 1'b0;
    store       = 1'b0;
    fifo_d      = fifo_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
    if (count_q != '0) begin
      store = push;
      if (head.dly == 4'd0) begin
        pop      = 1'b1;
        rvalid_d = 1'b1;
        rdata_d  = head.rdata;
        err_d    = head.err;
      end else begin
        fifo_d[rd_ptr_q].dly = head.dly - 4'd1;
      end
    end else if (push) begin
      if (d_draw == 4'd0) begin
        rvalid_d = 1'b1;
        rdata_d  = mem_rdata_i;
        err_d    = mem_err_i;
      end else begin
        store           = 1'b1;
        store_entry.dly = d_draw - 4'd1;
      end
    end
    if (store) fifo_d[wr_ptr_q] = store_entry;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CntW'(store) - CntW'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q       <= SeedEff;
      state_q      <= IDLE;
      cnt_q        <= '0;
      inflight_q   <= 1'b0;
      proto_err_q  <= 1'b0;
      hold_addr_q  <= '0;
      hold_we_q    <= 1'b0;
      hold_be_q    <= '0;
      hold_wdata_q <= '0;
      fifo_q       <= '{default: '0};
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      rvalid_q     <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
    end else begin
      lfsr_q       <= lfsr_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      inflight_q   <= inflight_d;
      proto_err_q  <= proto_err_d;
      hold_addr_q  <= hold_addr_d;
      hold_we_q    <= hold_we_d;
      hold_be_q    <= hold_be_d;
      hold_wdata_q <= hold_wdata_d;
      fifo_q       <= fifo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
    end
  end

  assign data_rvalid_o = rvalid_q;
  assign data_err_o    = err_q;
  assign data_rdata_o  = rdata_q;
  assign proto_err_o   = proto_err_q;

  // Grants are gated by occupancy, so a capture into a full queue means the
  // occupancy accounting is broken.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  !(push && count_q == CntW'(Depth)));

endmodule

// File: tb/tb_data_bus_lat_shim.sv
// Directed bench for data_bus_lat_shim: a zero-wait memory model answers
// every chip select, a negedge monitor scoreboards responses in grant order
// and tracks occupancy, and the main sequence walks the latency, ordering,
// back-pressure, protocol-error, reset and error-response scenarios.
module tb_data_bus_lat_shim;
  localparam int Depth = 4;
  localparam int DW    = 33;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [3:0]    gnt_wmax_i, resp_wmax_i;
  logic          data_req_i, data_we_i, data_is_cap_i;
  logic [3:0]    data_be_i;
  logic [31:0]   data_addr_i;
  logic [DW-1:0] data_wdata_i;
  logic          data_gnt_o, data_rvalid_o, data_err_o;
  logic [DW-1:0] data_rdata_o;
  logic          mem_cs_o, mem_we_o, mem_is_cap_o;
  logic [3:0]    mem_be_o;
  logic [31:0]   mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i = '0;
  logic          mem_err_i = 1'b0;
  logic          proto_err_o;

  data_bus_lat_shim #(.Depth(Depth), .DataWidth(DW), .Seed(16'hACE1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .gnt_wmax_i(gnt_wmax_i), .resp_wmax_i(resp_wmax_i),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_is_cap_i(data_is_cap_i), .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_err_o(data_err_o),
    .data_rdata_o(data_rdata_o), .mem_cs_o(mem_cs_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_is_cap_o(mem_is_cap_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
    .proto_err_o(proto_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Memory contents: 0x8000_0100 holds 1_DEADBEEF, other addresses differ.
  function automatic logic [32:0] mem_word(input logic [31:0] a);
    return {1'b1, 32'hDEADBEEF ^ a ^ 32'h8000_0100};
  endfunction

  logic        err_en = 1'b0;
  logic        cs_n = 1'b0, we_n = 1'b0;
  logic [31:0] addr_n = '0;

  always @(negedge clk_i) begin
    cs_n   = mem_cs_o;
    we_n   = mem_we_o;
    addr_n = mem_addr_o;
  end

  // Junk is driven when nothing was selected so a mistimed capture shows up.
  always @(posedge clk_i) begin
    #1;
    if (cs_n) begin
      mem_rdata_i = mem_word(addr_n);
      mem_err_i   = err_en & we_n;
    end else begin
      mem_rdata_i = 33'h0_BAD0BAD0;
      mem_err_i   = 1'b1;
    end
  end

  logic [33:0] exp_q[$];
  logic [33:0] e;
  int gnt_cyc_q[$];
  int rv_cyc_q[$];
  int gnt_total = 0, rv_total = 0, occ_viol = 0;

  always @(negedge clk_i) begin
    if (!rst_ni) begin
      exp_q.delete();
      gnt_total = 0;
      rv_total  = 0;
    end else begin
      if (data_rvalid_o) begin
        rv_total++;
        rv_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) chk("rvalid_unexpected", data_rvalid_o, 0);
        else begin
          e = exp_q.pop_front();
          chk("rdata", data_rdata_o, e[33:1]);
          chk("err", data_err_o, e[0]);
        end
      end
      if (data_gnt_o) begin
        if (gnt_total - rv_total >= Depth) occ_viol++;
        gnt_total++;
        gnt_cyc_q.push_back(cyc);
        exp_q.push_back({mem_word(data_addr_i), err_en & data_we_i});
      end
    end
  end

  task automatic drive(input logic we, input logic [31:0] a, input logic [32:0] wd);
    data_req_i    = 1'b1;
    data_we_i     = we;
    data_addr_i   = a;
    data_wdata_i  = wd;
    data_be_i     = 4'hF;
    data_is_cap_i = 1'b0;
  endtask

  // Holds the request until granted; returns #1 after the grant edge.
  task automatic issue(input logic we, input logic [31:0] a, input logic [32:0] wd);
    logic g;
    g = 1'b0;
    drive(we, a, wd);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_i);
      g = data_gnt_o;
      @(posedge clk_i);
      #1;
      if (g) return;
    end
    chk("gnt_timeout", g, 1);
  endtask

  task automatic wait_drain(input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) begin
      @(posedge clk_i);
      #1;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic lat_chk(input string tag, input int i);
    if (rv_cyc_q.size() > i && gnt_cyc_q.size() > i)
      chk(tag, rv_cyc_q[i] - gnt_cyc_q[i], 2);
    else
      chk({tag, "_missing"}, rv_cyc_q.size(), i + 1);
  endtask

  task automatic clr_hist();
    gnt_cyc_q.delete();
    rv_cyc_q.delete();
  endtask

  logic g4, found;

  initial begin
    rst_ni = 1'b0;
    gnt_wmax_i = 4'd0;
    resp_wmax_i = 4'd0;
    data_req_i = 1'b0; data_we_i = 1'b0; data_be_i = 4'h0; data_is_cap_i = 1'b0;
    data_addr_i = '0; data_wdata_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ctl", {data_gnt_o, data_rvalid_o, data_err_o, mem_cs_o, mem_we_o, proto_err_o}, 0);
    chk("rst_rdata", data_rdata_o, 0);
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;

    // 1: single read, zero waits
    clr_hist();
    drive(1'b0, 32'h8000_0100, '0);
    @(negedge clk_i);
    chk("t1_gnt", data_gnt_o, 1);
    chk("t1_cs", mem_cs_o, 1);
    chk("t1_maddr", mem_addr_o, 32'h8000_0100);
    chk("t1_mwe", mem_we_o, 0);
    @(posedge clk_i); #1 data_req_i = 1'b0;
    wait_drain(50);
    lat_chk("t1_lat", 0);
    chk("t1_rdata", data_rdata_o, 33'h1_DEADBEEF);
    chk("t1_err", data_err_o, 0);

    // 2: four back-to-back reads
    clr_hist();
    for (int i = 0; i < 4; i++) issue(1'b0, 32'h8000_0200 + 32'(4 * i), '0);
    data_req_i = 1'b0;
    wait_drain(50);
    for (int i = 0; i < 4; i++) begin
      lat_chk("t2_lat", i);
      if (gnt_cyc_q.size() > i) chk("t2_gnt_consec", gnt_cyc_q[i] - gnt_cyc_q[0], i);
    end
    chk("t2_last_rdata", data_rdata_o, 33'h1_DEADBDE3);

    // 3: random response delays, queue fills and back-pressures
    clr_hist();
    occ_viol = 0;
    resp_wmax_i = 4'd15;
    for (int i = 0; i < 6; i++) issue(1'b0, 32'h8000_0300 + 32'(4 * i), '0);
    data_req_i = 1'b0;
    wait_drain(400);
    chk("t3_occ_viol", occ_viol, 0);
    chk("t3_ngnt", gnt_cyc_q.size(), 6);
    chk("t3_nrsp", rv_cyc_q.size(), 6);
    chk("t3_no_pe", proto_err_o, 0);

    // 4: withdraw request while waiting
    resp_wmax_i = 4'd0;
    gnt_wmax_i = 4'd15;
    found = 1'b0;
    for (int a = 0; a < 40 && !found; a++) begin
      drive(1'b0, 32'h8000_0500, '0);
      @(negedge clk_i);
      g4 = data_gnt_o;
      @(posedge clk_i); #1;
      data_req_i = 1'b0;
      if (g4) begin
        @(posedge clk_i); #1;
      end else begin
        found = 1'b1;
        @(negedge clk_i);
        chk("t4_pe_pre", proto_err_o, 0);
        @(negedge clk_i);
        chk("t4_pe_set", proto_err_o, 1);
        repeat (10) @(negedge clk_i);
        chk("t4_pe_sticky", proto_err_o, 1);
        @(posedge clk_i); #1;
      end
    end
    chk("t4_wait_seen", found, 1);
    wait_drain(50);

    // 5: reset with accesses outstanding
    gnt_wmax_i = 4'd0;
    resp_wmax_i = 4'd15;
    for (int i = 0; i < 3; i++) issue(1'b0, 32'h8000_0600 + 32'(4 * i), '0);
    rst_ni = 1'b0;
    drive(1'b1, 32'h8000_0700, 33'h1_FFFF_FFFF);
    #1;
    chk("t5_rst_ctl", {data_gnt_o, data_rvalid_o, data_err_o, mem_cs_o, mem_we_o,
                       mem_is_cap_o, proto_err_o}, 0);
    chk("t5_rst_rdata", data_rdata_o, 0);
    chk("t5_rst_maddr", mem_addr_o, 0);
    chk("t5_rst_mwdata", mem_wdata_o, 0);
    chk("t5_rst_mbe", mem_be_o, 0);
    repeat (3) @(posedge clk_i);
    #1;
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    @(posedge clk_i); #1 rst_ni = 1'b1;
    repeat (20) @(posedge clk_i);
    @(negedge clk_i);
    chk("t5_no_rvalid", rv_total, 0);
    chk("t5_pe_clear", proto_err_o, 0);
    @(posedge clk_i); #1;

    // 6: write answered with an error
    resp_wmax_i = 4'd0;
    err_en = 1'b1;
    clr_hist();
    drive(1'b1, 32'h8000_0400, 33'h0_1234_5678);
    @(negedge clk_i);
    chk("t6_gnt", data_gnt_o, 1);
    chk("t6_mwe", mem_we_o, 1);
    chk("t6_mwdata", mem_wdata_o, 33'h0_1234_5678);
    @(posedge clk_i); #1 data_req_i = 1'b0;
    wait_drain(50);
    repeat (3) @(posedge clk_i);
    #1;
    lat_chk("t6_lat", 0);
    chk("t6_one_rsp", rv_cyc_q.size(), 1);
    chk("t6_err", data_err_o, 1);
    chk("t6_rdata", data_rdata_o, 33'h1_DEADBBEF);
    err_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_bus_lat_shim.md
# data_bus_lat_shim

Bus-latency shaping stage between the core data port (`data_*` on `ibex_top_tracing`) and a single-cycle data memory. Applies pseudo-random grant wait states (0..`gnt_wmax_i`) and response delays (0..`resp_wmax_i`) to the OBI-style handshake. Queues outstanding responses in order and flags requester protocol violations. Used in the CHERIoT DV bench so that timing stress can be applied in front of a plain zero-wait memory.

## Interface
Parameters:
- `Depth`, 4: maximum outstanding accesses, counted as FIFO entries plus the in-flight memory access; range 2..8.
- `DataWidth`, 33: width of read and write data, including the capability tag bit.
- `Seed`, 16'hACE1: LFSR reset value. A value of 0 is replaced by 16'h0001.

Ports:
- `clk_i` in 1: clock.
- `rst_ni` in 1: asynchronous active-low reset.
- `gnt_wmax_i` in 4: maximum grant wait, in cycles.
- `resp_wmax_i` in 4: maximum extra response delay, in cycles.
- `data_req_i`, `data_we_i` in 1 each: core request and write enable.
- `data_be_i` in 4: core byte enables.
- `data_is_cap_i` in 1: core capability-access flag.
- `data_addr_i` in 32: core address.
- `data_wdata_i` in `DataWidth`: core write data.
- `data_gnt_o`, `data_rvalid_o`, `data_err_o` out 1 each: grant, response valid and response error to the core.
- `data_rdata_o` out `DataWidth`: response data to the core.
- `mem_cs_o`, `mem_we_o` out 1 each: memory chip select and write enable.
- `mem_be_o` out 4: memory byte enables.
- `mem_is_cap_o` out 1: capability flag to memory.
- `mem_addr_o` out 32: memory address.
- `mem_wdata_o` out `DataWidth`: memory write data.
- `mem_rdata_i` in `DataWidth`: memory read data, valid the cycle after `mem_cs_o`.
- `mem_err_i` in 1: memory error, valid the cycle after `mem_cs_o`.
- `proto_err_o` out 1: sticky protocol-violation flag.

## Operation
- **LFSR:** 16-bit Galois LFSR, polynomial 16'hB400, advances every cycle.
  - Grant wait draw: `w = lfsr[3:0] % (gnt_wmax_i+1)`.
  - Response delay draw: `d = lfsr[7:4] % (resp_wmax_i+1)`.
- **Occupancy:** `occ = fifo_count + inflight`.
  - `space = (occ < Depth)`.
  - `inflight` is set on the grant cycle and cleared on the following cycle.
- **Grant FSM states: IDLE, WAIT.**
  - IDLE with `data_req_i`: draw `w`.
    - If `w==0` and `space`: `data_gnt_o=1` combinationally, stay in IDLE.
    - Otherwise go to WAIT with `cnt=w`.
  - WAIT: `cnt` decrements while nonzero.
    - When `cnt==0`, `space` and `data_req_i` are all true: `data_gnt_o=1`, go to IDLE.
  - WAIT with `data_req_i==0`: set `proto_err_o`, go to IDLE.
  - A request must not change `addr`, `we`, `be` or `wdata` in WAIT. A change sets `proto_err_o`.
- **Forwarding:** in the grant cycle, `mem_cs_o = data_gnt_o`. The request fields pass straight through to `mem_*`. `mem_*` fields are don't-care when `mem_cs_o=0`.
- **Capture:** the cycle after a grant, push {`mem_rdata_i`, `mem_err_i`, `d`} into the FIFO. `mem_rdata_i` is stored for writes too.
- **Release:**
  - The head delay decrements each cycle while nonzero.
  - When the head delay is 0, register `data_rvalid_o=1` with the head's rdata and err for exactly one cycle, then pop.
  - At most one pop per cycle. Responses stay strictly in grant order.
- `data_err_o` and `data_rdata_o` are meaningful only with `data_rvalid_o`. They hold their last values otherwise.
- Push and pop in the same cycle are allowed. `fifo_count` is then unchanged.
- Overflow cannot occur, because grant is gated by `space`. Reaching a FIFO push at count == `Depth` is a design error and fires an assertion.

## Timing
- **Reset (async, `rst_ni` low):**
  - All outputs are 0.
  - FSM goes to IDLE, FIFO is emptied, `inflight=0`, `proto_err_o=0`, LFSR loads `Seed`.
- **Mid-operation reset:** outstanding accesses are dropped silently. No `data_rvalid_o` is issued for them after release.
- **Grant latency:** from `data_req_i` high to `data_gnt_o`, 0..`gnt_wmax_i` cycles, plus any stall while `occ==Depth`.
- **Response latency:** with `resp_wmax_i=0` and an empty FIFO, grant at cycle N gives `data_rvalid_o` at N+2. Each unit of `d` adds 1 cycle. Queueing behind earlier entries adds further cycles.
- **Throughput:** with both wmax inputs at 0, a continuous request stream is granted every cycle and responded to every cycle.
- **Updates:** changes to `gnt_wmax_i` and `resp_wmax_i` affect only draws taken after the change.

## Test plan
1. `gnt_wmax=0`, `resp_wmax=0`; read `addr` 32'h8000_0100 with memory returning 33'h1_DEADBEEF -> grant in the same cycle (N), `mem_cs_o` at N, `data_rvalid_o` at N+2 with rdata 33'h1_DEADBEEF and err 0.
2. Both wmax 0; 4 back-to-back reads to 0x..00, 0x..04, 0x..08, 0x..0C -> 4 consecutive grants, then 4 consecutive rvalids in the same order with matching data.
3. `resp_wmax=15`; 6 queued reads -> `data_gnt_o` stays low while `occ==4`, all 6 responses return in order, none lost or duplicated.
4. `gnt_wmax=15`; drop `data_req_i` while in WAIT -> `proto_err_o` goes to 1 the next cycle and stays 1 until reset.
5. Assert reset with 3 accesses outstanding -> all outputs 0 within the reset, and no `data_rvalid_o` for 20 cycles after release.
6. Write with `mem_err_i=1`, both wmax 0 -> `data_rvalid_o` and `data_err_o` both 1 at N+2.
